// File: rtl/uart_pkg.sv
// Shared constants and drain FSM encoding for the UART receive path.
package uart_pkg;

    localparam int WIDTH_DATA_DEF = 8;
    localparam int WIDTH_DIV_DEF  = 16;
    localparam int MIN_DIV        = 2;

    typedef enum logic {
        CTRL_IDLE = 1'b0,
        CTRL_ACK  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-rate strobe generator: counts 0..D-1, high for the second half of the period,
// re-phased to zero by a start-edge pulse so receiver sampling lands mid-bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int WIDTH_DIV = WIDTH_DIV_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_en,
    input  logic [WIDTH_DIV-1:0] i_div,
    input  logic                 i_srst_clk,
    output logic                 o_clk_rx
);

    logic [WIDTH_DIV-1:0] cnt_q;
    logic [WIDTH_DIV-1:0] cnt_next;
    logic [WIDTH_DIV-1:0] div_q;
    logic [WIDTH_DIV-1:0] d_cur;
    logic [WIDTH_DIV-1:0] half;
    logic                 clk_q;
    logic                 clk_next;

    // The divisor is only sampled while cnt sits at 0 (wrap, re-phase or disabled),
    // so a mid-period change cannot shorten the period and create an extra edge.
    always_comb begin
        d_cur = div_q;
        if (cnt_q == '0) begin
            d_cur = (i_div < WIDTH_DIV'(MIN_DIV)) ? WIDTH_DIV'(MIN_DIV) : i_div;
        end
        half = d_cur >> 1;

        if (i_srst_clk || !i_en) begin
            cnt_next = '0;
        end else if (cnt_q == d_cur - 1'b1) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_q + 1'b1;
        end

        clk_next = !i_srst_clk && i_en && (cnt_next >= half);
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            cnt_q <= '0;
            div_q <= WIDTH_DIV'(MIN_DIV);
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_next;
            div_q <= d_cur;
            clk_q <= clk_next;
        end
    end

    assign o_clk_rx = clk_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud strobe, receiver drain handshake and core-side stream buffer.
// Define RX_FIFO_EN for a circular FIFO of 2**DEPTH_LOG2 words; otherwise a single holding register.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int WIDTH_DATA = WIDTH_DATA_DEF,
    parameter int WIDTH_DIV  = WIDTH_DIV_DEF,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_en,
    input  logic [WIDTH_DIV-1:0]  i_div,
    output logic                  o_clk_rx,
    input  logic                  i_srst_clk,
    input  logic                  i_rx_rdy,
    input  logic [WIDTH_DATA-1:0] i_rx_data,
    output logic                  o_rx_re,
    output logic                  o_valid,
    output logic [WIDTH_DATA-1:0] o_data,
    input  logic                  i_ready,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_ovr,
    input  logic                  i_ovr_clr,
    output ctrl_state_e           o_state
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        full;
    logic        drop;
    logic        ovr_q;

    uart_baud_gen #(.WIDTH_DIV(WIDTH_DIV)) u_baud_gen (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_en       (i_en),
        .i_div      (i_div),
        .i_srst_clk (i_srst_clk),
        .o_clk_rx   (o_clk_rx)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state_q <= CTRL_IDLE;
        else         state_q <= state_d;
    end

    // ACK waits for the receiver to drop ready so a word is never taken twice.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CTRL_IDLE: if (i_rx_rdy)  state_d = CTRL_ACK;
            CTRL_ACK:  if (!i_rx_rdy) state_d = CTRL_IDLE;
            default:   state_d = CTRL_IDLE;
        endcase
    end

    always_comb begin
        push_req = (state_q == CTRL_IDLE) && i_rx_rdy;
        o_rx_re  = push_req;
        o_state  = state_q;
    end

    // A pop frees a slot in the same cycle, so push-on-full with pop is not an overrun.
    assign pop  = o_valid && i_ready;
    assign push = push_req && (!full || pop);
    assign drop = push_req && full && !pop;

`ifdef RX_FIFO_EN
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH_DATA-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= i_rx_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (!push && pop) level_q <= level_q - 1'b1;
        end
    end

    assign full    = (level_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign o_valid = (level_q != '0);
    assign o_data  = mem_q[rd_ptr_q];
    assign o_level = level_q;
`else
    logic [WIDTH_DATA-1:0] hold_q;
    logic                  hold_valid_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            if (push) hold_q <= i_rx_data;
            hold_valid_q <= push || (hold_valid_q && !pop);
        end
    end

    assign full    = hold_valid_q;
    assign o_valid = hold_valid_q;
    assign o_data  = hold_q;
    assign o_level = {{DEPTH_LOG2{1'b0}}, hold_valid_q};
`endif

    // Set has priority over clear when both land in the same cycle.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)        ovr_q <= 1'b0;
        else if (drop)      ovr_q <= 1'b1;
        else if (i_ovr_clr) ovr_q <= 1'b0;
    end

    assign o_ovr = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: baud re-phase, drain handshake, buffer/overrun, reset.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int W  = 8;
    localparam int WD = 16;
    localparam int DL = 2;

    logic          i_clk;
    logic          i_nrst;
    logic          i_en;
    logic [WD-1:0] i_div;
    logic          o_clk_rx;
    logic          i_srst_clk;
    logic          i_rx_rdy;
    logic [W-1:0]  i_rx_data;
    logic          o_rx_re;
    logic          o_valid;
    logic [W-1:0]  o_data;
    logic          i_ready;
    logic [DL:0]   o_level;
    logic          o_ovr;
    logic          i_ovr_clr;
    ctrl_state_e   o_state;

    uart_rx_ctrl #(.WIDTH_DATA(W), .WIDTH_DIV(WD), .DEPTH_LOG2(DL)) dut (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_en       (i_en),
        .i_div      (i_div),
        .o_clk_rx   (o_clk_rx),
        .i_srst_clk (i_srst_clk),
        .i_rx_rdy   (i_rx_rdy),
        .i_rx_data  (i_rx_data),
        .o_rx_re    (o_rx_re),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_ready    (i_ready),
        .o_level    (o_level),
        .o_ovr      (o_ovr),
        .i_ovr_clr  (i_ovr_clr),
        .o_state    (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int nvec   = 0;
    int nerr   = 0;
    int re_cnt = 0;

    always @(negedge i_clk) if (o_rx_re === 1'b1) re_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic push_word(input logic [W-1:0] d);
        i_rx_rdy  = 1'b1;
        i_rx_data = d;
        tick();
        i_rx_rdy  = 1'b0;
        tick();
    endtask

    logic [W-1:0] exp_seq [4] = '{8'h22, 8'h33, 8'h44, 8'h77};
    int           re0;

    initial begin
        i_nrst = 1'b0; i_en = 1'b0; i_div = 16'd16; i_srst_clk = 1'b0;
        i_rx_rdy = 1'b0; i_rx_data = '0; i_ready = 1'b0; i_ovr_clr = 1'b0;

        // reset state
        #12;
        chk("rst_clk_rx", 32'(o_clk_rx), 0);
        chk("rst_rx_re",  32'(o_rx_re),  0);
        chk("rst_valid",  32'(o_valid),  0);
        chk("rst_data",   32'(o_data),   0);
        chk("rst_level",  32'(o_level),  0);
        chk("rst_ovr",    32'(o_ovr),    0);
        #10 i_nrst = 1'b1;
        tick();

        // baud generator: re-phase at E, D=16, HALF=8
        i_en = 1'b1;
        ticks(20);
        i_srst_clk = 1'b1;
        tick();
        i_srst_clk = 1'b0;
        chk("rephase_E",    32'(o_clk_rx), 0);
        ticks(7); chk("E_plus_7",  32'(o_clk_rx), 0);
        tick();   chk("E_plus_8",  32'(o_clk_rx), 1);
        ticks(7); chk("E_plus_15", 32'(o_clk_rx), 1);
        tick();   chk("E_plus_16", 32'(o_clk_rx), 0);
        ticks(7); chk("E_plus_23", 32'(o_clk_rx), 0);
        tick();   chk("E_plus_24", 32'(o_clk_rx), 1);
        ticks(13); chk("cnt5_low", 32'(o_clk_rx), 0);

        // second re-phase at cnt=5: old-phase rise suppressed
        i_srst_clk = 1'b1;
        tick();
        i_srst_clk = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("rephase2_low", 32'(o_clk_rx), 0);
        end
        tick(); chk("rephase2_rise", 32'(o_clk_rx), 1);

        // mid-period divisor change waits for the wrap
        i_div = 16'd4;
        ticks(7); chk("div_hold",  32'(o_clk_rx), 1);
        tick();   chk("div_wrap",  32'(o_clk_rx), 0);
        ticks(2); chk("div4_rise", 32'(o_clk_rx), 1);
        tick();   chk("div4_hi",   32'(o_clk_rx), 1);
        tick();   chk("div4_fall", 32'(o_clk_rx), 0);
        i_div = 16'd0;
        tick();   chk("div0_rise", 32'(o_clk_rx), 1);
        tick();   chk("div0_fall", 32'(o_clk_rx), 0);
        tick();
        i_en = 1'b0;
        tick();   chk("en_off",    32'(o_clk_rx), 0);
        i_div = 16'd16;

        // drain handshake: rdy held 3 cycles
        re0 = re_cnt;
        i_rx_rdy = 1'b1; i_rx_data = 8'hA5;
        #1;
        chk("re_same_cycle", 32'(o_rx_re), 1);
        chk("valid_before",  32'(o_valid), 0);
        tick();
        chk("re_drop",      32'(o_rx_re), 0);
        chk("drain_valid",  32'(o_valid), 1);
        chk("drain_level",  32'(o_level), 1);
        chk("drain_data",   32'(o_data),  32'h0A5);
        ticks(2);
        i_rx_rdy = 1'b0;
        tick();
        chk("one_re_pulse", 32'(re_cnt - re0), 1);
        chk("no_dbl_push",  32'(o_level), 1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("pop_empty_valid", 32'(o_valid), 0);
        chk("pop_empty_level", 32'(o_level), 0);

`ifdef RX_FIFO_EN
        for (int d = 1; d <= 4; d++) push_word(W'(d));
        i_rx_rdy = 1'b1; i_rx_data = 8'h05; i_ovr_clr = 1'b1;
        tick();
        i_rx_rdy = 1'b0; i_ovr_clr = 1'b0;
        tick();
        chk("ovr_set_wins", 32'(o_ovr),   1);
        chk("full_level",   32'(o_level), 4);
        chk("full_head",    32'(o_data),  1);
        i_ready = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            chk("pop_order", 32'(o_data), 32'(d));
            tick();
        end
        i_ready = 1'b0;
        chk("drained_valid", 32'(o_valid), 0);
        chk("drained_level", 32'(o_level), 0);
        chk("ovr_sticky",    32'(o_ovr),   1);
        i_ovr_clr = 1'b1; tick(); i_ovr_clr = 1'b0;
        chk("ovr_clr", 32'(o_ovr), 0);

        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        chk("full2_level", 32'(o_level), 4);
        i_rx_rdy = 1'b1; i_rx_data = 8'h77; i_ready = 1'b1;
        tick();
        i_rx_rdy = 1'b0;
        chk("pushpop_level", 32'(o_level), 4);
        chk("pushpop_ovr",   32'(o_ovr),   0);
        for (int i = 0; i < 4; i++) begin
            chk("pushpop_order", 32'(o_data), 32'(exp_seq[i]));
            tick();
        end
        i_ready = 1'b0;
        chk("pushpop_empty", 32'(o_valid), 0);
`else
        push_word(8'h01);
        chk("hold_level", 32'(o_level), 1);
        i_rx_rdy = 1'b1; i_rx_data = 8'h02; i_ovr_clr = 1'b1;
        tick();
        i_rx_rdy = 1'b0; i_ovr_clr = 1'b0;
        tick();
        chk("ovr_set_wins", 32'(o_ovr),   1);
        chk("full_level",   32'(o_level), 1);
        chk("full_head",    32'(o_data),  1);
        i_ready = 1'b1; tick(); i_ready = 1'b0;
        chk("drained_valid", 32'(o_valid), 0);
        chk("ovr_sticky",    32'(o_ovr),   1);
        i_ovr_clr = 1'b1; tick(); i_ovr_clr = 1'b0;
        chk("ovr_clr", 32'(o_ovr), 0);

        push_word(8'h11);
        i_rx_rdy = 1'b1; i_rx_data = 8'h77; i_ready = 1'b1;
        tick();
        i_rx_rdy = 1'b0; i_ready = 1'b0;
        chk("pushpop_level", 32'(o_level), 1);
        chk("pushpop_ovr",   32'(o_ovr),   0);
        chk("pushpop_data",  32'(o_data),  32'h077);
        i_ready = 1'b1; tick(); i_ready = 1'b0;
        chk("pushpop_empty", 32'(o_valid), 0);
`endif

        // reset mid-handshake
        i_en = 1'b1;
        push_word(8'h31);
        i_rx_rdy = 1'b1; i_rx_data = 8'h32;
        tick();
`ifdef RX_FIFO_EN
        chk("pre_rst_level", 32'(o_level), 2);
`else
        chk("pre_rst_level", 32'(o_level), 1);
        chk("pre_rst_ovr",   32'(o_ovr),   1);
`endif
        chk("pre_rst_state", 32'(o_state), 32'(CTRL_ACK));
        i_nrst = 1'b0; i_rx_rdy = 1'b0;
        #1;
        chk("async_clk_rx", 32'(o_clk_rx), 0);
        chk("async_rx_re",  32'(o_rx_re),  0);
        chk("async_valid",  32'(o_valid),  0);
        chk("async_data",   32'(o_data),   0);
        chk("async_level",  32'(o_level),  0);
        chk("async_ovr",    32'(o_ovr),    0);
        chk("async_state",  32'(o_state),  32'(CTRL_IDLE));
        #3 i_nrst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("post_rst_low", 32'(o_clk_rx), 0);
        end
        tick();
        chk("post_rst_half", 32'(o_clk_rx), 1);
        chk("post_rst_empty", 32'(o_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
